aes_serial_host: RTL
====================

Name: aes_serial_host

Overview:
- Host-side driver for the byte-serial AES cipher core interface: the strobe-driven 8-bit-in / 16-bit-out port used by the decipher top.
- Accepts a 128-bit block and 128-bit key in parallel on start.
- Streams them MSB byte first using sig_in/sig_sft strobes, waits for the core to settle, then pulls eight 16-bit words with sig_out and reassembles the 128-bit result.
- Sits between system logic and the cipher top level.

Parameters:
WAIT_CYCLES, 4, idle cycles between the last byte load and the first sig_out pulse (core settle time); legal 0..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin transaction; sampled only in IDLE
block_in  input  128  block to process; byte 0 = [127:120]
key_in  input  128  key; same byte order
data_out  output  8  byte to core data input
key_out  output  8  byte to core key input
sig_in  output  1  load strobe to core
sig_sft  output  1  shift strobe to core
sig_out  output  1  read strobe to core
word_in  input  16  core 16-bit output word
block_out  output  128  reassembled result; word 0 = [127:112]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, block_out valid

Behaviour:
- One clock domain; rst is asynchronous, active-high.
- Reset: state=IDLE; data_out=0, key_out=0, sig_in=0, sig_sft=0, sig_out=0; block_out=0, busy=0, done=0; byte_idx=0, word_idx=0, wait_cnt=0.
- All outputs are registered.
- At most one strobe is high in any cycle. Every strobe pulse is exactly 1 cycle and is followed by at least 1 cycle with all strobes low, because the core is edge/level sensitive on the strobes.
- IDLE: when start=1, latch block_in/key_in into internal registers, byte_idx=0, go to LOAD. Later changes to block_in/key_in have no effect.
- LOAD: data_out=blk[127-8*byte_idx -: 8], key_out=key at the same slice, sig_in=1. Go to LGAP.
- LGAP: strobes low; data_out/key_out held. If byte_idx=15, go to WAIT with wait_cnt=0; else go to SHIFT.
- SHIFT: sig_sft=1. Go to SGAP.
- SGAP: strobes low; byte_idx+1. Go to LOAD.
- Per transaction: 16 sig_in pulses and 15 sig_sft pulses, so byte 0 ends in core bits [127:120].
- WAIT: stay WAIT_CYCLES cycles (0 means pass through without stalling), then go to OUT with word_idx=0.
- OUT: sig_out=1. Go to OGAP.
- OGAP: strobes low. Capture word_in into a shadow register at [127-16*word_idx -: 16]. If word_idx=7, go to DONE; else word_idx+1 and go to OUT.
- DONE: block_out=shadow, done=1 for one cycle. Go to IDLE.
- block_out changes only in DONE and holds until the next DONE.
- Latency: done rises 78+WAIT_CYCLES clock edges after the edge that samples start (82 at default).
- start while busy: ignored, not queued. start in the DONE cycle is also ignored. start is accepted from the first IDLE cycle onward.
- data_out/key_out keep their last LOAD value outside LOAD/LGAP; they change only on entry to LOAD.
- Reset mid-transaction: immediate return to reset values; no done pulse; partial shadow discarded.
- The core's read counter is not resettable, so the host issues exactly 8 sig_out pulses per transaction, never more.

Optional Feature:
AES_HOST_ABORT_EN
- Defined: adds input port abort (1 bit).
- abort=1 in any non-IDLE state forces IDLE on the next edge. All strobes go low that edge; no done pulse; block_out unchanged; shadow discarded.
- abort in IDLE has no effect.
- abort has priority over start in the same cycle.
- Undefined: no port, and the FSM has no abort path.

Test Plan:
1. Reset check: assert rst async mid-cycle -> all outputs 0 immediately; busy=0.
2. FIPS-197 decrypt vector: block_in=69c4e0d86a7b0430d8cdb78070b4c55a, key_in=000102030405060708090a0b0c0d0e0f, behavioural core model attached -> block_out=00112233445566778899aabbccddeeff; done one cycle, 82 clocks after start edge.
3. Strobe protocol monitor on test 2: exactly 16 sig_in, 15 sig_sft, 8 sig_out pulses; no two strobes high together; no back-to-back strobe cycles; first data_out=69, last=5a.
4. start pulsed at clocks 10 and 40 after acceptance -> ignored; exactly one done; block_out unchanged by them.
5. WAIT_CYCLES=0 instance -> done at 78 clocks; same result as test 2. rst asserted during the OUT phase -> no done; next transaction completes correctly with a fresh core model.
6. AES_HOST_ABORT_EN: abort during SHIFT of byte 7 -> IDLE next edge, strobes low, no done, block_out keeps prior value; a new start then completes normally.

Source files
------------

// File: rtl/aes_serial_host_if.sv
// Byte-serial bus between the host driver and the AES cipher core.
// Host drives the byte lanes and the three strobes; the core returns 16-bit words.
// master = host side, slave = core side.
interface aes_serial_host_if;
  logic [7:0]  data_out;
  logic [7:0]  key_out;
  logic        sig_in;
  logic        sig_sft;
  logic        sig_out;
  logic [15:0] word_in;

  modport master (
    output data_out,
    output key_out,
    output sig_in,
    output sig_sft,
    output sig_out,
    input  word_in
  );

  modport slave (
    input  data_out,
    input  key_out,
    input  sig_in,
    input  sig_sft,
    input  sig_out,
    output word_in
  );
endinterface

// File: rtl/aes_serial_host.sv
// Host driver: loads a 128-bit block/key into the byte-serial AES core and reads back 8 words.
// Latency: done rises 78+WAIT_CYCLES edges after the edge that accepts start.
// No backpressure: start is taken only in IDLE and ignored otherwise; optional abort via AES_HOST_ABORT_EN.
module aes_serial_host #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef AES_HOST_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] block_in,
  input  logic [127:0] key_in,
  aes_serial_host_if.master core,
  output logic [127:0] block_out,
  output logic         busy,
  output logic         done
);

  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [7:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    LGAP,
    SHIFT,
    SGAP,
    WAIT,
    OUT,
    OGAP,
    DONE
  } state_t;

  state_t        state;
  // Bytes 1..15 of the latched block/key; byte 0 goes straight to the lanes on accept.
  logic [119:0]  blk;
  logic [119:0]  key;
  logic [3:0]    byte_idx;
  logic [2:0]    word_idx;
  logic [7:0]    wait_cnt;
  // Words 0..6 collected so far; word 7 is appended directly on the way to block_out.
  logic [111:0]  shadow;

  // Sequencer: every output is set on the edge entering the state that presents it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      blk           <= '0;
      key           <= '0;
      byte_idx      <= '0;
      word_idx      <= '0;
      wait_cnt      <= '0;
      shadow        <= '0;
      core.data_out <= '0;
      core.key_out  <= '0;
      core.sig_in   <= 1'b0;
      core.sig_sft  <= 1'b0;
      core.sig_out  <= 1'b0;
      block_out     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Strobes and done are single-cycle; only the entering transition raises them.
      core.sig_in  <= 1'b0;
      core.sig_sft <= 1'b0;
      core.sig_out <= 1'b0;
      done         <= 1'b0;
`ifdef AES_HOST_ABORT_EN
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            if (start) begin
              blk           <= block_in[119:0];
              key           <= key_in[119:0];
              byte_idx      <= '0;
              core.data_out <= block_in[127:120];
              core.key_out  <= key_in[127:120];
              core.sig_in   <= 1'b1;
              busy          <= 1'b1;
              state         <= LOAD;
            end
          end
          LOAD: state <= LGAP;
          LGAP: begin
            if (byte_idx == 4'd15) begin
              wait_cnt <= '0;
              if (HAS_WAIT) begin
                state <= WAIT;
              end else begin
                word_idx     <= '0;
                core.sig_out <= 1'b1;
                state        <= OUT;
              end
            end else begin
              core.sig_sft <= 1'b1;
              state        <= SHIFT;
            end
          end
          SHIFT: state <= SGAP;
          SGAP: begin
            byte_idx      <= byte_idx + 4'd1;
            core.data_out <= blk[119:112];
            core.key_out  <= key[119:112];
            blk           <= {blk[111:0], 8'h00};
            key           <= {key[111:0], 8'h00};
            core.sig_in   <= 1'b1;
            state         <= LOAD;
          end
          WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              word_idx     <= '0;
              core.sig_out <= 1'b1;
              state        <= OUT;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          OUT: state <= OGAP;
          OGAP: begin
            // The core presents the word during the gap following its sig_out pulse.
            shadow <= {shadow[95:0], core.word_in};
            if (word_idx == 3'd7) begin
              block_out <= {shadow, core.word_in};
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              word_idx     <= word_idx + 3'd1;
              core.sig_out <= 1'b1;
              state        <= OUT;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
